// File: rtl/sram_ctrl_if.sv
// Pipeline-side request/response bus of the shared instruction/data SRAM controller.
// The pipeline is the master. The controller is the slave.
interface sram_ctrl_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_inst;
  logic              if_ack;
  logic              mem_rd;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;
  logic              stall_req;

  modport master (
    output if_req, if_addr, mem_rd, mem_wr, mem_addr, mem_wdata,
    input  if_inst, if_ack, mem_rdata, mem_ack, stall_req
  );

  modport slave (
    input  if_req, if_addr, mem_rd, mem_wr, mem_addr, mem_wdata,
    output if_inst, if_ack, mem_rdata, mem_ack, stall_req
  );
endinterface

// File: rtl/sram_ctrl.sv
// Single-port async SRAM controller arbitrating fetch and load/store requests.
// Define SRAM_CTRL_FBUF_EN to add the one-entry fetch buffer.
module sram_ctrl #(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 16,
  parameter int RD_WAIT  = 1,
  parameter int WR_PULSE = 1
) (
  input  logic              clk,
  input  logic              rst,
  sram_ctrl_if.slave        bus,
  output logic [ADDR_W-1:0] sram_addr,
  inout  wire  [DATA_W-1:0] sram_data,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n
);

  typedef enum logic [2:0] {IDLE, RD, WR_SU, WR_PW, WR_HD, DONE} state_t;
  typedef enum logic {SRC_IF, SRC_MEM} src_t;

  state_t            state_q, state_d;
  src_t              src_q;
  logic [2:0]        cnt_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] if_inst_q;
  logic [DATA_W-1:0] mem_rdata_q;
  logic              drive;
  logic              last_rd, last_pw;
  logic              fbuf_hit;
  logic [DATA_W-1:0] fbuf_inst;

  assign last_rd = (cnt_q == 3'(RD_WAIT));
  assign last_pw = (cnt_q == 3'(WR_PULSE - 1));

`ifdef SRAM_CTRL_FBUF_EN
  logic              fb_valid;
  logic [ADDR_W-1:0] fb_addr;
  logic [DATA_W-1:0] fb_inst;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fb_valid <= 1'b0;
      fb_addr  <= '0;
      fb_inst  <= '0;
    end else if (state_q == RD && last_rd && src_q == SRC_IF) begin
      fb_valid <= 1'b1;
      fb_addr  <= sram_addr;
      fb_inst  <= sram_data;
    end else if (state_q == WR_HD && sram_addr == fb_addr) begin
      fb_valid <= 1'b0;
    end
  end

  assign fbuf_hit  = fb_valid && (bus.if_addr == fb_addr);
  assign fbuf_inst = fb_inst;
`else
  assign fbuf_hit  = 1'b0;
  assign fbuf_inst = '0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // updates from the pre-edge values, independent of process ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // NOTE: every combinational output gets a default first so no path leaves
  // it unassigned and infers a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (bus.mem_wr)      state_d = WR_SU;
        else if (bus.mem_rd) state_d = RD;
        else if (bus.if_req) state_d = fbuf_hit ? DONE : RD;
      end
      RD:      if (last_rd) state_d = DONE;
      WR_SU:   state_d = WR_PW;
      WR_PW:   if (last_pw) state_d = WR_HD;
      WR_HD:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    sram_ce_n   = 1'b1;
    sram_oe_n   = 1'b1;
    sram_we_n   = 1'b1;
    drive       = 1'b0;
    bus.if_ack  = 1'b0;
    bus.mem_ack = 1'b0;
    unique case (state_q)
      RD: begin
        sram_ce_n = 1'b0;
        sram_oe_n = 1'b0;
      end
      WR_SU, WR_HD: begin
        sram_ce_n = 1'b0;
        drive     = 1'b1;
      end
      WR_PW: begin
        sram_ce_n = 1'b0;
        sram_we_n = 1'b0;
        drive     = 1'b1;
      end
      DONE: begin
        bus.if_ack  = (src_q == SRC_IF);
        bus.mem_ack = (src_q == SRC_MEM);
      end
      default: ;
    endcase
  end

  // Address, write data and requester are frozen at grant for the whole access.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q       <= '0;
      src_q       <= SRC_IF;
      sram_addr   <= '0;
      wdata_q     <= '0;
      if_inst_q   <= '0;
      mem_rdata_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (bus.mem_wr) begin
            sram_addr <= bus.mem_addr;
            wdata_q   <= bus.mem_wdata;
            src_q     <= SRC_MEM;
          end else if (bus.mem_rd) begin
            sram_addr <= bus.mem_addr;
            src_q     <= SRC_MEM;
          end else if (bus.if_req) begin
            sram_addr <= bus.if_addr;
            src_q     <= SRC_IF;
            if (fbuf_hit) if_inst_q <= fbuf_inst;
          end
        end
        RD: begin
          if (last_rd) begin
            cnt_q <= '0;
            if (src_q == SRC_IF) if_inst_q   <= sram_data;
            else                 mem_rdata_q <= sram_data;
          end else begin
            cnt_q <= cnt_q + 3'd1;
          end
        end
        WR_PW:   cnt_q <= last_pw ? 3'd0 : cnt_q + 3'd1;
        default: cnt_q <= '0;
      endcase
    end
  end

  assign sram_data     = drive ? wdata_q : 'z;
  assign bus.if_inst   = if_inst_q;
  assign bus.mem_rdata = mem_rdata_q;
  assign bus.stall_req = (bus.if_req & ~bus.if_ack)
                       | ((bus.mem_rd | bus.mem_wr) & ~bus.mem_ack);

endmodule

// File: tb/tb_sram_ctrl.sv
// Directed self-checking bench for sram_ctrl with a behavioural async SRAM model.
// Build with SRAM_CTRL_FBUF_EN defined to exercise the fetch-buffer hit path.
module tb_sram_ctrl;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [ADDR_W-1:0] sram_addr;
  wire  [DATA_W-1:0] sram_data;
  logic              sram_ce_n, sram_oe_n, sram_we_n;

  int n_cmp = 0;
  int n_err = 0;

  sram_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  sram_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_WAIT(1), .WR_PULSE(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .sram_addr (sram_addr),
    .sram_data (sram_data),
    .sram_ce_n (sram_ce_n),
    .sram_oe_n (sram_oe_n),
    .sram_we_n (sram_we_n)
  );

  always #5 clk = ~clk;

  // Async SRAM model: drives on read enable, writes mid-pulse on the falling edge.
  logic [DATA_W-1:0] sram_mem [0:1023];
  assign sram_data = (!sram_ce_n && !sram_oe_n) ? sram_mem[sram_addr[9:0]] : 'z;
  always @(negedge clk)
    if (!sram_ce_n && !sram_we_n) sram_mem[sram_addr[9:0]] <= sram_data;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Steps until the selected ack is seen; lat stays 0 if the bound expires.
  task automatic run_until_ack(input bit is_if, output int lat, output int ce_cnt);
    lat    = 0;
    ce_cnt = 0;
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (!sram_ce_n) ce_cnt++;
      if (is_if ? bus.if_ack : bus.mem_ack) begin
        lat = k;
        break;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat, ce_cnt, we_low, mem_k, if_k, ack_cnt;
    bit stall_ok;

    for (int i = 0; i < 1024; i++) sram_mem[i] = 16'h0000;
    sram_mem[10'h010] = 16'h1234;
    sram_mem[10'h002] = 16'h2222;
    sram_mem[10'h200] = 16'h3333;
    sram_mem[10'h020] = 16'h7777;
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.mem_rd = 1'b0; bus.mem_wr  = 1'b0;
    bus.mem_addr = '0; bus.mem_wdata = '0;

    // Reset values
    #12;
    check("rst_ce_n", sram_ce_n, 1);
    check("rst_oe_n", sram_oe_n, 1);
    check("rst_we_n", sram_we_n, 1);
    check("rst_if_ack", bus.if_ack, 0);
    check("rst_mem_ack", bus.mem_ack, 0);
    check("rst_sram_addr", sram_addr, 0);
    check("rst_if_inst", bus.if_inst, 0);
    check("rst_mem_rdata", bus.mem_rdata, 0);
    check("rst_stall", bus.stall_req, 0);
    rst = 1'b1;
    tick();

    // Reset asserted while in RD
    bus.if_req = 1'b1; bus.if_addr = 16'h0010;
    tick();
    check("midrd_in_rd_ce_n", sram_ce_n, 0);
    check("midrd_in_rd_oe_n", sram_oe_n, 0);
    #1 rst = 1'b0;
    #1;
    check("midrd_ce_n", sram_ce_n, 1);
    check("midrd_oe_n", sram_oe_n, 1);
    check("midrd_if_ack", bus.if_ack, 0);
    check("midrd_sram_addr", sram_addr, 0);
    bus.if_req = 1'b0;
    #2 rst = 1'b1;

    // Plain fetch, 3-cycle latency
    bus.if_req = 1'b1; bus.if_addr = 16'h0010;
    for (int k = 1; k <= 3; k++) begin
      tick();
      if (k < 3) begin
        check($sformatf("fetch_ack_early_k%0d", k), bus.if_ack, 0);
        check($sformatf("fetch_stall_k%0d", k), bus.stall_req, 1);
      end
    end
    check("fetch_ack", bus.if_ack, 1);
    check("fetch_inst", bus.if_inst, 16'h1234);
    check("fetch_stall_ack", bus.stall_req, 0);
    bus.if_req = 1'b0;
    tick();
    check("fetch_ack_gone", bus.if_ack, 0);
    check("fetch_inst_hold", bus.if_inst, 16'h1234);

    // Store 0xBEEF to 0x0100; inputs changed after grant must not matter
    bus.mem_wr = 1'b1; bus.mem_addr = 16'h0100; bus.mem_wdata = 16'hBEEF;
    we_low = 0;
    tick();
    check("wr_su_ce_n", sram_ce_n, 0);
    check("wr_su_we_n", sram_we_n, 1);
    check("wr_su_oe_n", sram_oe_n, 1);
    check("wr_su_data", sram_data, 16'hBEEF);
    bus.mem_addr = 16'h0101; bus.mem_wdata = 16'hDEAD;
    tick();
    if (!sram_we_n) we_low++;
    check("wr_pw_we_n", sram_we_n, 0);
    check("wr_pw_data", sram_data, 16'hBEEF);
    check("wr_pw_addr", sram_addr, 16'h0100);
    tick();
    if (!sram_we_n) we_low++;
    check("wr_hd_we_n", sram_we_n, 1);
    check("wr_hd_data", sram_data, 16'hBEEF);
    tick();
    if (!sram_we_n) we_low++;
    check("wr_ack", bus.mem_ack, 1);
    check("wr_done_ce_n", sram_ce_n, 1);
    check("wr_we_low_cycles", we_low, 1);
    check("wr_mem_contents", sram_mem[10'h100], 16'hBEEF);
    bus.mem_wr = 1'b0;
    tick();

    // Load back 0x0100
    bus.mem_rd = 1'b1; bus.mem_addr = 16'h0100;
    run_until_ack(1'b0, lat, ce_cnt);
    check("ld_latency", lat, 3);
    check("ld_rdata", bus.mem_rdata, 16'hBEEF);
    bus.mem_rd = 1'b0;
    tick();

    // Fetch and load together: data first, fetch after one idle cycle
    bus.if_req = 1'b1; bus.if_addr = 16'h0002;
    bus.mem_rd = 1'b1; bus.mem_addr = 16'h0200;
    mem_k = 0; if_k = 0; stall_ok = 1'b1;
    for (int k = 1; k <= 10 && if_k == 0; k++) begin
      tick();
      if (k == 1) check("prio_addr", sram_addr, 16'h0200);
      if (bus.mem_ack) begin mem_k = k; bus.mem_rd = 1'b0; end
      if (bus.if_ack) begin if_k = k; bus.if_req = 1'b0; end
      else if (!bus.stall_req) stall_ok = 1'b0;
    end
    check("prio_mem_ack_cycle", mem_k, 3);
    check("prio_if_ack_cycle", if_k, 7);
    check("prio_stall_continuous", stall_ok, 1);
    check("prio_mem_rdata", bus.mem_rdata, 16'h3333);
    check("prio_if_inst", bus.if_inst, 16'h2222);
    tick();

    // Load and store together: treated as store
    bus.mem_rd = 1'b1; bus.mem_wr = 1'b1;
    bus.mem_addr = 16'h0004; bus.mem_wdata = 16'h00AA;
    mem_k = 0; ack_cnt = 0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (bus.mem_ack) begin
        ack_cnt++;
        mem_k = k;
        bus.mem_rd = 1'b0; bus.mem_wr = 1'b0;
      end
    end
    check("rdwr_ack_cycle", mem_k, 4);
    check("rdwr_ack_count", ack_cnt, 1);
    check("rdwr_rdata_unchanged", bus.mem_rdata, 16'h3333);
    check("rdwr_mem_contents", sram_mem[10'h004], 16'h00AA);

    // Fetch 0x0020 twice
    bus.if_req = 1'b1; bus.if_addr = 16'h0020;
    run_until_ack(1'b1, lat, ce_cnt);
    check("fb1_latency", lat, 3);
    check("fb1_inst", bus.if_inst, 16'h7777);
    bus.if_req = 1'b0;
    tick();
    bus.if_req = 1'b1;
    run_until_ack(1'b1, lat, ce_cnt);
`ifdef SRAM_CTRL_FBUF_EN
    check("fb2_latency", lat, 1);
    check("fb2_ce_cycles", ce_cnt, 0);
`else
    check("fb2_latency", lat, 3);
    check("fb2_ce_cycles", ce_cnt, 2);
`endif
    check("fb2_inst", bus.if_inst, 16'h7777);
    bus.if_req = 1'b0;
    tick();

    // Store to the fetched address, then fetch must see the new data
    bus.mem_wr = 1'b1; bus.mem_addr = 16'h0020; bus.mem_wdata = 16'h5555;
    run_until_ack(1'b0, lat, ce_cnt);
    check("fb_st_latency", lat, 4);
    bus.mem_wr = 1'b0;
    tick();
    bus.if_req = 1'b1; bus.if_addr = 16'h0020;
    run_until_ack(1'b1, lat, ce_cnt);
    check("fb3_latency", lat, 3);
    check("fb3_ce_cycles", ce_cnt, 2);
    check("fb3_inst", bus.if_inst, 16'h5555);
    bus.if_req = 1'b0;
    tick();
    check("final_stall", bus.stall_req, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/sram_ctrl.md
Name: sram_ctrl

Overview:
- Single-port external SRAM controller; the responder side of the pipeline's shared instruction/data memory interface.
- Serves two requesters: the fetch port (PC address, returns instruction) and the MEM-stage data port (load/store).
- Drives the SRAM chip pins through a multi-cycle read/write state machine.
- Raises stall_req to the pipeline stall controller while any request is pending and not yet acknowledged.

Parameters:
ADDR_W, 16, address width in words
DATA_W, 16, data/instruction width
RD_WAIT, 1, cycles in RD state before data capture (1..7)
WR_PULSE, 1, cycles sram_we_n is held low (1..7)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-low reset
if_req  input  1  fetch request, level, held until if_ack
if_addr  input  ADDR_W  fetch word address
if_inst  output  DATA_W  fetched instruction, valid when if_ack=1
if_ack  output  1  one-cycle fetch completion pulse
mem_rd  input  1  data load request, level, held until mem_ack
mem_wr  input  1  data store request, level, held until mem_ack
mem_addr  input  ADDR_W  data word address
mem_wdata  input  DATA_W  store data
mem_rdata  output  DATA_W  load data, valid when mem_ack=1
mem_ack  output  1  one-cycle data completion pulse
stall_req  output  1  pipeline stall request
sram_addr  output  ADDR_W  SRAM address pins
sram_data  inout  DATA_W  SRAM bidirectional data pins
sram_ce_n  output  1  chip enable, active-low
sram_oe_n  output  1  output enable, active-low
sram_we_n  output  1  write enable, active-low

Behaviour:
- States: IDLE, RD, WR_SU, WR_PW, WR_HD, DONE.
- Reset (async, rst=0), effective immediately, including mid-operation:
  - state IDLE; counter 0.
  - if_inst, mem_rdata, sram_addr = 0.
  - if_ack, mem_ack = 0.
  - sram_ce_n, sram_oe_n, sram_we_n = 1; sram_data high-Z.
- IDLE: requests are sampled on the rising edge.
  - Priority: mem_wr > mem_rd > if_req.
  - The granted address is latched into sram_addr and the requester is recorded.
  - mem_wr -> WR_SU. mem_rd or if_req -> RD.
  - mem_rd and mem_wr both high is treated as a write.
- RD: ce_n=0, oe_n=0, we_n=1; stay RD_WAIT+1 cycles.
  - On the last RD edge, sram_data is captured into if_inst or mem_rdata (the recorded requester's register only); next state DONE.
- WR_SU: ce_n=0, oe_n=1, we_n=1; sram_data driven with latched mem_wdata; 1 cycle.
- WR_PW: we_n=0, data driven; WR_PULSE cycles.
- WR_HD: we_n=1, data still driven; 1 cycle; then DONE.
- DONE: ce_n=1, oe_n=1; recorded requester's ack = 1 for exactly this cycle; next IDLE unconditionally.
  - No back-to-back issue; minimum idle gap is 1 cycle.
- sram_data is driven only in WR_SU/WR_PW/WR_HD, high-Z in all other states. The controller never drives while oe_n=0.
- Latency, request sampled at edge E0 to ack-high cycle:
  - Read: RD_WAIT+2 cycles.
  - Write: WR_PULSE+3 cycles.
- if_inst/mem_rdata hold their last captured value until the next capture of the same port.
- stall_req (combinational) = (if_req & ~if_ack) | ((mem_rd|mem_wr) & ~mem_ack).
- A requester dropping its request before ack does not abort the access. The access completes, the ack still pulses, and the ack is ignored by the requester.
- A non-granted request stays pending and is served from the next IDLE; if_req waits behind continuous data traffic.
- Address and write data are latched at grant; later input changes do not affect the access in flight.

Optional Feature:
SRAM_CTRL_FBUF_EN
- Defined: one-entry fetch buffer holding {valid, addr, inst}, reset valid=0.
  - Loaded on every completed SRAM fetch.
  - In IDLE, if if_req is granted with if_addr == buffered addr and valid=1: next state DONE directly, no SRAM cycle, ce_n stays 1, if_inst = buffered inst. Hit latency is 1 cycle.
  - Any completed write with mem_addr == buffered addr clears valid.
- Undefined: no buffer; every fetch performs a full SRAM read.

Test Plan:
- Reset mid-RD (rst low while in RD) -> same cycle: ce_n=oe_n=1, sram_data high-Z, acks 0; after release, state IDLE and first request is served normally.
- if_req=1, if_addr=0x0010, SRAM[0x0010]=0x1234, RD_WAIT=1 -> if_ack high exactly 3 cycles after sample edge, if_inst=0x1234, stall_req high until ack cycle.
- mem_wr=1, mem_addr=0x0100, mem_wdata=0xBEEF, WR_PULSE=1 -> we_n low exactly 1 cycle, data driven WR_SU..WR_HD only, mem_ack at cycle 4; a following load of 0x0100 returns 0xBEEF.
- if_req and mem_rd both asserted in IDLE, addrs 0x0002/0x0200 -> data read first (mem_ack), then fetch (if_ack). if_ack is 1 idle cycle plus read latency after mem_ack; stall_req is continuous until if_ack.
- mem_rd and mem_wr asserted together, mem_addr=0x0004, mem_wdata=0x00AA -> write performed, mem_ack once, mem_rdata unchanged.
- FBUF_EN: fetch 0x0020 twice -> second if_ack 1 cycle after sample with no ce_n activity. After a store to 0x0020 of 0x5555, the next fetch goes to SRAM and returns 0x5555.
